// File: rtl/stopwatch_pkg.sv
// Shared types and segment encoding for the stopwatch display link.
// Segment byte layout is {dp,g,f,e,d,c,b,a}, active-high.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    LATCH
  } tx_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // BCD to {g,f,e,d,c,b,a}; non-decimal codes blank the digit
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_serial_tx_enc.sv
// One-digit 7-segment encoder: BCD plus decimal point to a display byte.
// Purely combinational; one instance per digit in the transmitter.
module seg7_encoder
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {dp, bcd_to_seg(bcd)};

endmodule

// File: rtl/seven_seg_serial_tx.sv
// Serial transmitter for a 74HC595-style display chain.
// Encodes captured digits, shifts them MSB-first, then pulses the latch.
module seven_seg_serial_tx
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic                    busy,
  output logic                    done,
  output logic                    ser_data,
  output logic                    ser_clk,
  output logic                    ser_latch
);

  localparam int N  = 8 * NUM_DIGITS;
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(N);

  localparam logic [DW-1:0] DIV_HI  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_END = DW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_END = BW'(N - 1);

  tx_state_t               state_q, state_d;
  logic [DW-1:0]           div_q, div_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [N-2:0]            sreg_q, sreg_d;
  logic [4*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic                    data_q, data_d;
  logic                    sclk_q, sclk_d;
  logic                    latch_q, latch_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [N-1:0]            frame;

  // Per-digit encoders; digit k lands in byte k so the top digit leaves first
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_enc
    seg7_encoder u_enc (
      .bcd (dig_q[4*k +: 4]),
      .dp  (dp_q[k]),
      .seg (frame[8*k +: 8])
    );
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    dig_d   = dig_q;
    dp_d    = dp_q;
    data_d  = data_q;
    sclk_d  = sclk_q;
    latch_d = latch_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dig_d   = digits_bcd;
          dp_d    = dp;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_d  = frame[N-1];
        sreg_d  = frame[N-2:0];
        sclk_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        div_d = div_q + DW'(1);
        if (div_q == DIV_HI) begin
          sclk_d = 1'b1;
        end
        if (div_q == DIV_END) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == BIT_END) begin
            bit_d   = '0;
            data_d  = 1'b0;
            latch_d = 1'b1;
            state_d = LATCH;
          end else begin
            bit_d  = bit_q + BW'(1);
            data_d = sreg_q[N-2];
            sreg_d = {sreg_q[N-3:0], 1'b0};
          end
        end
      end
      LATCH: begin
        div_d = div_q + DW'(1);
        if (div_q == DIV_HI) begin
          div_d   = '0;
          latch_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any frame in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      dig_q   <= '0;
      dp_q    <= '0;
      data_q  <= 1'b0;
      sclk_q  <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      dig_q   <= dig_d;
      dp_q    <= dp_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      latch_q <= latch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ser_data  = data_q;
  assign ser_clk   = sclk_q;
  assign ser_latch = latch_q;

endmodule

// File: tb/tb_seven_seg_serial_tx.sv
// Bench for seven_seg_serial_tx: directed frames with a byte/done scoreboard.
// Two instances: default geometry and a 1-digit, CLK_DIV=1 build.
module tb_seven_seg_serial_tx;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  logic        start0, busy0, done0, sd0, sc0, sl0;
  logic [15:0] dig0;
  logic [3:0]  dp0;

  logic        start1, busy1, done1, sd1, sc1, sl1;
  logic [3:0]  dig1;
  logic [0:0]  dp1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         dq0[$];
  int         dq1[$];
  int         lat0 = 0;
  int         lat1 = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  seven_seg_serial_tx #(.NUM_DIGITS(4), .CLK_DIV(4)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start0),
    .digits_bcd (dig0),
    .dp         (dp0),
    .busy       (busy0),
    .done       (done0),
    .ser_data   (sd0),
    .ser_clk    (sc0),
    .ser_latch  (sl0)
  );

  seven_seg_serial_tx #(.NUM_DIGITS(1), .CLK_DIV(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .digits_bcd (dig1),
    .dp         (dp1),
    .busy       (busy1),
    .done       (done1),
    .ser_data   (sd1),
    .ser_clk    (sc1),
    .ser_latch  (sl1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Monitor for the 4-digit instance
  initial begin : mon0
    int         nb;
    logic [7:0] acc;
    logic       pc, pl;
    nb = 0; acc = '0; pc = 1'b0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nb = 0; pc = 1'b0; pl = 1'b0;
      end else begin
        if (sc0 && !pc) begin
          acc = {acc[6:0], sd0};
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (q0.size() == 0) flag("byte0_unexpected");
            else chk("byte0", acc, q0.pop_front());
          end
        end
        if (sl0 && !pl) begin
          lat0++;
          chk("latch0_align", nb, 0);
        end
        if (done0) begin
          if (dq0.size() == 0) flag("done0_unexpected");
          else chk("done0_cycle", cyc, dq0.pop_front());
        end
        pc = sc0;
        pl = sl0;
      end
    end
  end

  // Monitor for the 1-digit instance
  initial begin : mon1
    int         nb;
    logic [7:0] acc;
    logic       pc, pl;
    nb = 0; acc = '0; pc = 1'b0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        nb = 0; pc = 1'b0; pl = 1'b0;
      end else begin
        if (sc1 && !pc) begin
          acc = {acc[6:0], sd1};
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (q1.size() == 0) flag("byte1_unexpected");
            else chk("byte1", acc, q1.pop_front());
          end
        end
        if (sl1 && !pl) begin
          lat1++;
          chk("latch1_align", nb, 0);
        end
        if (done1) begin
          if (dq1.size() == 0) flag("done1_unexpected");
          else chk("done1_cycle", cyc, dq1.pop_front());
        end
        pc = sc1;
        pl = sl1;
      end
    end
  end

  task automatic send0(input logic [15:0] d, input logic [3:0] p,
                       input logic [31:0] b, output int c);
    @(negedge clk);
    dig0 = d; dp0 = p; start0 = 1'b1; c = cyc;
    for (int i = 3; i >= 0; i--) q0.push_back(b[8*i +: 8]);
    dq0.push_back(c + 262);
    @(negedge clk);
    start0 = 1'b0;
    chk("busy0_load", busy0, 1);
  endtask

  task automatic drain0(input int budget);
    int n;
    n = 0;
    while (dq0.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (dq0.size() != 0) begin
      flag("timeout0");
      dq0.delete();
      q0.delete();
    end
    chk("bytes0_left", q0.size(), 0);
  endtask

  task automatic drain1(input int budget);
    int n;
    n = 0;
    while (dq1.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (dq1.size() != 0) begin
      flag("timeout1");
      dq1.delete();
      q1.delete();
    end
    chk("bytes1_left", q1.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c, lb;
    rst = 1'b1;
    start0 = 1'b0; dig0 = '0; dp0 = '0;
    start1 = 1'b0; dig1 = '0; dp1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_data", sd0, 0);
    chk("rst_sclk", sc0, 0);
    chk("rst_latch", sl0, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame with a decimal point on digit 2
    send0(16'h1234, 4'b0100, 32'h06DB4F66, c);
    drain0(400);

    // Non-decimal codes blank
    send0(16'h9A0F, 4'b0000, 32'h6F003F00, c);
    drain0(400);

    // Restarts and input changes mid-frame are ignored
    send0(16'h4567, 4'b0000, 32'h666D7D07, c);
    repeat (4) @(negedge clk);
    start0 = 1'b1; dig0 = 16'h1111; dp0 = 4'b1111;
    @(negedge clk);
    start0 = 1'b0;
    repeat (94) @(negedge clk);
    chk("restart_cycle", cyc, c + 100);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    drain0(400);
    repeat (300) @(negedge clk);
    chk("no_extra_frame", busy0, 0);

    // Asynchronous abort during bit 10
    send0(16'h2222, 4'b0000, 32'h5B5B5B5B, c);
    repeat (84) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", busy0, 0);
    chk("abort_done", done0, 0);
    chk("abort_data", sd0, 0);
    chk("abort_sclk", sc0, 0);
    chk("abort_latch", sl0, 0);
    q0.delete();
    dq0.delete();
    lb = lat0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort_no_latch", lat0, lb);
    send0(16'h5678, 4'b1000, 32'hED7D077F, c);
    drain0(400);

    // Start held high: two back-to-back frames
    @(negedge clk);
    dig0 = 16'h0000; dp0 = 4'b1111; start0 = 1'b1; c = cyc;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 4; i++) q0.push_back(8'hBF);
    dq0.push_back(c + 262);
    dq0.push_back(c + 524);
    repeat (263) @(negedge clk);
    chk("b2b_reload", busy0, 1);
    repeat (261) @(negedge clk);
    start0 = 1'b0;
    drain0(400);
    repeat (20) @(negedge clk);
    chk("b2b_stop", busy0, 0);

    // Single digit, fastest shift clock
    @(negedge clk);
    dig1 = 4'h8; dp1 = 1'b0; start1 = 1'b1; c = cyc;
    q1.push_back(8'h7F);
    dq1.push_back(c + 19);
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      chk("fast_sclk", sc1, i % 2);
      @(negedge clk);
    end
    drain1(100);

    repeat (10) @(negedge clk);
    chk("latch0_total", lat0, 6);
    chk("latch1_total", lat1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
